// File: rtl/dp_sequencer.sv
// dp_sequencer: 16-word program store and FETCH/EXEC control FSM for the 8-bit RF/ALU datapath.
// Two cycles per instruction; `SEQ_WATCHDOG_EN` adds an EXEC-count watchdog that aborts with err.
module dp_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int WDOG_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic        lt,
  output logic        RF_Src_Mux_Sel,
  output logic [2:0]  r_addr_1,
  output logic [2:0]  r_addr_2,
  output logic [2:0]  wr_addr,
  output logic        wr_en,
  output logic [1:0]  opcode,
  output logic        outport_en
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  localparam logic [2:0] C_ALU  = 3'b000;
  localparam logic [2:0] C_LDI1 = 3'b001;
  localparam logic [2:0] C_OUT  = 3'b010;
  localparam logic [2:0] C_BLT  = 3'b011;
  localparam logic [2:0] C_JMP  = 3'b100;
  localparam logic [2:0] C_HALT = 3'b101;

  localparam logic [7:0] WDOG_LIM8 = 8'(WDOG_LIMIT);

  state_t      state;
  logic [3:0]  pc;
  logic [15:0] ir;
  logic        done_q;
  logic        err_q;
  logic [15:0] store [PROG_DEPTH];

  logic [2:0] cls, rd, rs1, rs2;
  logic [3:0] target;
  logic [1:0] aluop;
  logic       taken;
  logic [3:0] pc_next;
  logic       wdog_trip;

  assign cls    = ir[15:13];
  assign rd     = ir[12:10];
  assign rs1    = ir[9:7];
  assign rs2    = ir[6:4];
  assign target = ir[3:0];
  assign aluop  = ir[1:0];

  assign taken   = (cls == C_JMP) || ((cls == C_BLT) && lt);
  assign pc_next = taken ? target : pc + 4'd1;

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign err  = err_q;

  // Store is loadable only while idle; it is deliberately not reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE)) begin
      store[prog_addr] <= prog_data;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  logic [7:0] wdog_cnt;

  // Trips on the EXEC that brings the count up to the limit.
  assign wdog_trip = (wdog_cnt == (WDOG_LIM8 - 8'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt <= 8'd0;
    end else if ((state == S_IDLE) && start) begin
      wdog_cnt <= 8'd0;
    end else if (state == S_EXEC) begin
      wdog_cnt <= wdog_cnt + 8'd1;
    end
  end
`else
  logic unused_wdog;

  assign wdog_trip   = 1'b0;
  assign unused_wdog = &{1'b0, WDOG_LIM8};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      pc     <= 4'd0;
      ir     <= 16'd0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= 4'd0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir    <= store[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (cls == C_HALT) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else if (wdog_trip) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            pc    <= pc_next;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read ports follow rs1/rs2 for every class so lt is valid during a BLT EXEC.
  always_comb begin
    RF_Src_Mux_Sel = 1'b0;
    r_addr_1       = 3'd0;
    r_addr_2       = 3'd0;
    wr_addr        = 3'd0;
    wr_en          = 1'b0;
    opcode         = 2'b00;
    outport_en     = 1'b0;
    if (state == S_EXEC) begin
      r_addr_1 = rs1;
      r_addr_2 = rs2;
      case (cls)
        C_ALU: begin
          wr_en   = 1'b1;
          wr_addr = rd;
          opcode  = aluop;
        end
        C_LDI1: begin
          wr_en          = 1'b1;
          wr_addr        = rd;
          RF_Src_Mux_Sel = 1'b1;
        end
        C_OUT:   outport_en = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Scoreboard bench for dp_sequencer with a behavioural register-file/ALU datapath.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'd0;
  logic [15:0] prog_data = 16'd0;
  logic        busy, done, err, lt;
  logic        RF_Src_Mux_Sel, wr_en, outport_en;
  logic [2:0]  r_addr_1, r_addr_2, wr_addr;
  logic [1:0]  opcode;

  always #5 clk = ~clk;

  dp_sequencer #(.PROG_DEPTH(16), .WDOG_LIMIT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .lt(lt),
    .RF_Src_Mux_Sel(RF_Src_Mux_Sel), .r_addr_1(r_addr_1), .r_addr_2(r_addr_2),
    .wr_addr(wr_addr), .wr_en(wr_en), .opcode(opcode), .outport_en(outport_en)
  );

  // Behavioural datapath: R0 reads 0, unsigned lt, OutPort latched on outport_en.
  logic [7:0] regs [8] = '{default: 8'h00};
  logic [7:0] rd1, rd2, alu_y;
  logic [7:0] outport = 8'h00;

  assign rd1 = (r_addr_1 == 3'd0) ? 8'h00 : regs[r_addr_1];
  assign rd2 = (r_addr_2 == 3'd0) ? 8'h00 : regs[r_addr_2];
  assign lt  = (rd1 < rd2);

  always_comb begin
    alu_y = 8'h00;
    case (opcode)
      2'b00: alu_y = rd1 + rd2;
      2'b01: alu_y = rd1 - rd2;
      2'b10: alu_y = rd1 & rd2;
      2'b11: alu_y = rd1 | rd2;
      default: alu_y = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (wr_en) regs[wr_addr] <= RF_Src_Mux_Sel ? 8'h01 : alu_y;
    if (outport_en) outport <= rd1;
  end

  localparam int K_OUT  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  busy_cnt = 0;
  int  blt_cnt = 0;
  bit  prev_busy = 1'b0;

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input int val, input string name);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event (value %0d), required nothing", name, val);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val != val) begin
        n_fail++;
        $display("FAIL %s: got kind %0d value %0d, required kind %0d value %0d",
                 name, kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (busy && lt && r_addr_1 == 3'd6 && r_addr_2 == 3'd4 && !wr_en && !outport_en)
        blt_cnt++;
      if (outport_en) expect_ev(K_OUT, int'(rd1), "outport");
      if (done) begin
        expect_ev(K_DONE, busy_cnt, "done_busy_cycles");
        n_checks++;
        if (!prev_busy || busy) begin
          n_fail++;
          $display("FAIL done_timing: prev_busy=%0b busy=%0b, required 1 and 0", prev_busy, busy);
        end
        busy_cnt = 0;
      end
      if (err) begin
        expect_ev(K_ERR, busy_cnt, "err_busy_cycles");
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic int ctrl_vec();
    return int'({RF_Src_Mux_Sel, r_addr_1, r_addr_2, wr_addr, wr_en, opcode, outport_en});
  endfunction

  function automatic logic [15:0] enc(input logic [2:0] c, input logic [2:0] d,
                                      input logic [2:0] a, input logic [2:0] b,
                                      input logic [3:0] lo);
    return {c, d, a, b, lo};
  endfunction
  function automatic logic [15:0] i_alu(input logic [2:0] d, input logic [2:0] a,
                                        input logic [2:0] b, input logic [1:0] op);
    return enc(3'b000, d, a, b, {2'b00, op});
  endfunction
  function automatic logic [15:0] i_ldi(input logic [2:0] d);
    return enc(3'b001, d, 3'd0, 3'd0, 4'd0);
  endfunction
  function automatic logic [15:0] i_out(input logic [2:0] a);
    return enc(3'b010, 3'd0, a, 3'd0, 4'd0);
  endfunction
  function automatic logic [15:0] i_blt(input logic [2:0] a, input logic [2:0] b, input logic [3:0] t);
    return enc(3'b011, 3'd0, a, b, t);
  endfunction
  function automatic logic [15:0] i_jmp(input logic [3:0] t);
    return enc(3'b100, 3'd0, 3'd0, 3'd0, t);
  endfunction
  function automatic logic [15:0] i_halt();
    return enc(3'b101, 3'd0, 3'd0, 3'd0, 4'd0);
  endfunction
  function automatic logic [15:0] i_nop(input logic [2:0] c);
    return enc(c, 3'd0, 3'd0, 3'd0, 4'd0);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] w);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = w;
    tick(1);
    prog_we = 1'b0;
  endtask

  task automatic load_loop();
    load(4'd0,  i_ldi(3'd1));
    load(4'd1,  i_alu(3'd2, 3'd1, 3'd1, 2'b00));
    load(4'd2,  i_alu(3'd3, 3'd2, 3'd2, 2'b00));
    load(4'd3,  i_alu(3'd4, 3'd3, 3'd1, 2'b00));
    load(4'd4,  i_alu(3'd5, 3'd0, 3'd0, 2'b00));
    load(4'd5,  i_alu(3'd6, 3'd0, 3'd0, 2'b00));
    load(4'd6,  i_alu(3'd6, 3'd6, 3'd1, 2'b00));
    load(4'd7,  i_alu(3'd5, 3'd5, 3'd6, 2'b00));
    load(4'd8,  i_blt(3'd6, 3'd4, 4'd6));
    load(4'd9,  i_out(3'd5));
    load(4'd10, i_halt());
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: run timed out with %0d events pending, busy=%0b, required 0 pending and idle",
               name, sb.size(), busy);
      sb.delete();
    end
    tick(2);
  endtask

  initial begin
    int blt0;
    int idle_busy;

    // Reset state
    tick(2);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    check("reset_ctrl", ctrl_vec(), 0);
    rst = 1'b1;
    idle_busy = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      idle_busy |= int'(busy) | int'(done);
    end
    check("idle_no_start", idle_busy, 0);
    check("idle_ctrl", ctrl_vec(), 0);

    // LDI1 R1; R2 = R1 + R1; OUT R2; HALT
    load(4'd0, i_ldi(3'd1));
    load(4'd1, i_alu(3'd2, 3'd1, 3'd1, 2'b00));
    load(4'd2, i_out(3'd2));
    load(4'd3, i_halt());
    push(K_OUT, 2);
    push(K_DONE, 8);
    pulse_start();
    drain(100, "prog_basic");
    check("basic_outport", int'(outport), 8'h02);

    // Each ALU opcode: 3 = 2|1, 6 = 3+3, 5 = 6-1, 4 = 5&6
    load(4'd0, i_ldi(3'd1));
    load(4'd1, i_alu(3'd2, 3'd1, 3'd1, 2'b00));
    load(4'd2, i_alu(3'd3, 3'd2, 3'd1, 2'b11));
    load(4'd3, i_alu(3'd4, 3'd3, 3'd3, 2'b00));
    load(4'd4, i_alu(3'd5, 3'd4, 3'd1, 2'b01));
    load(4'd5, i_alu(3'd6, 3'd5, 3'd4, 2'b10));
    load(4'd6, i_out(3'd3));
    load(4'd7, i_out(3'd5));
    load(4'd8, i_out(3'd6));
    load(4'd9, i_halt());
    push(K_OUT, 3);
    push(K_OUT, 5);
    push(K_OUT, 4);
    push(K_DONE, 20);
    pulse_start();
    drain(100, "prog_aluops");

    // Triangular-sum loop: 1+2+3+4+5 = 15, BLT taken 4 times, 23 instructions
    load_loop();
    push(K_OUT, 15);
    push(K_DONE, 46);
    blt0 = blt_cnt;
    pulse_start();
    drain(200, "prog_loop");
    check("loop_blt_taken", blt_cnt - blt0, 4);
    check("loop_outport", int'(outport), 8'h0F);

    // PC wrap: BLT to 13, LDI1 R7, JMP 15, NOP at 15, wrap to 0, BLT falls through, OUT R7, HALT
    load(4'd0,  i_blt(3'd7, 3'd1, 4'd13));
    load(4'd1,  i_out(3'd7));
    load(4'd2,  i_halt());
    load(4'd13, i_ldi(3'd7));
    load(4'd14, i_jmp(4'd15));
    load(4'd15, i_nop(3'b110));
    push(K_OUT, 1);
    push(K_DONE, 14);
    pulse_start();
    drain(100, "prog_wrap");

    // Store write and start while busy are ignored
    load_loop();
    push(K_OUT, 15);
    push(K_DONE, 46);
    pulse_start();
    tick(10);
    prog_we   = 1'b1;
    prog_addr = 4'd9;
    prog_data = i_halt();
    start     = 1'b1;
    tick(1);
    prog_we = 1'b0;
    start   = 1'b0;
    drain(200, "prog_busy_write");
    push(K_OUT, 15);
    push(K_DONE, 46);
    pulse_start();
    drain(200, "prog_store_intact");

    // Write and start in the same idle cycle: execution sees the new word
    load(4'd10, i_out(3'd1));
    load(4'd11, i_halt());
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = i_jmp(4'd10);
    start     = 1'b1;
    tick(1);
    prog_we = 1'b0;
    start   = 1'b0;
    push(K_OUT, 1);
    push(K_DONE, 6);
    drain(100, "prog_write_start");
    load(4'd0, i_ldi(3'd1));
    load(4'd10, i_halt());

    // Asynchronous reset mid-program, then restart from PC 0
    pulse_start();
    tick(7);
    rst = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done_err", int'({done, err}), 0);
    check("midrst_ctrl", ctrl_vec(), 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    check("midrst_idle", int'(busy), 0);
    push(K_OUT, 15);
    push(K_DONE, 46);
    pulse_start();
    drain(200, "prog_after_reset");

`ifdef SEQ_WATCHDOG_EN
    load(4'd0, i_jmp(4'd0));
    push(K_ERR, 510);
    pulse_start();
    drain(700, "prog_watchdog");
    check("wdog_busy_low", int'(busy), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
